// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS multicycle fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/fetch_unit_instr_reg.sv
// Instruction register: load-enabled capture, async clear, raw field slices.
module instr_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 32'h0;
    else if (load) q <= d;
  end

  assign opcode = q[OP_MSB:OP_LSB];
  assign rs     = q[RS_MSB:RS_LSB];
  assign rt     = q[RT_MSB:RT_LSB];
  assign imm    = q[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, memory read handshake with bounded wait, redirect loading.
// Build option: ALIGN_CHECK_EN turns misaligned redirects into an exception-vector load.
//
// Handshake: mem_rd is held high for every FETCH cycle; a fetch completes on
// the first rising edge where mem_rd and mem_ready are both high.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          WAIT_MAX   = 16,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_start,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  inst25_21,
  output logic [4:0]  inst20_16,
  output logic [15:0] inst15_0,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err,
  output logic        addr_err,
  output logic [1:0]  dbg_state
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          idle_or_hold;
  logic          capture;
  logic          timeout;
  logic          misaligned;
  logic [31:0]   redirect_pc;

  assign idle_or_hold = (state == IDLE) || (state == HOLD);
  assign capture      = (state == FETCH) && mem_ready;
  assign timeout      = (state == FETCH) && !mem_ready && (wait_cnt == CNT_LAST);

`ifdef ALIGN_CHECK_EN
  assign misaligned  = (redirect_target[1:0] != 2'b00);
  assign redirect_pc = misaligned ? EXC_VECTOR : redirect_target;
`else
  assign misaligned  = 1'b0;
  assign redirect_pc = {redirect_target[31:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, HOLD: if (fetch_start) state_next = FETCH;
      FETCH: begin
        if (mem_ready) state_next = HOLD;
        else if (timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Redirects only land between fetches so the address never moves under mem_rd.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      fetch_err <= timeout;
      addr_err  <= idle_or_hold && redirect && misaligned;
      if (idle_or_hold && redirect) pc <= redirect_pc;
      else if (capture) pc <= pc_plus4;
      if (idle_or_hold && fetch_start) wait_cnt <= '0;
      else if ((state == FETCH) && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  instr_reg u_instr_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (capture),
    .d      (mem_rdata),
    .q      (instr),
    .opcode (opcode),
    .rs     (inst25_21),
    .rt     (inst20_16),
    .imm    (inst15_0)
  );

  assign pc_plus4    = pc + 32'd4;
  assign mem_addr    = pc;
  assign mem_rd      = (state == FETCH);
  assign busy        = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign dbg_state   = state;

endmodule
